// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX stage register: control bundle layout and
// the occupancy state encoding.
package id_ex_pkg;

    localparam int unsigned CTRL_W = 13;

    // Control bundle {ALUOP, ALUSRC, BrLogic, ThreeWay, RegWrite, Asig, MemRead, MemWrite}
    localparam int unsigned ALUOP_LSB    = 10;
    localparam int unsigned ALUOP_W      = 3;
    localparam int unsigned ALUSRC_LSB   = 8;
    localparam int unsigned ALUSRC_W     = 2;
    localparam int unsigned BRLOGIC_LSB  = 6;
    localparam int unsigned BRLOGIC_W    = 2;
    localparam int unsigned THREEWAY_LSB = 4;
    localparam int unsigned THREEWAY_W   = 2;
    localparam int unsigned REGWRITE_BIT = 3;
    localparam int unsigned ASIG_BIT     = 2;
    localparam int unsigned MEMREAD_BIT  = 1;
    localparam int unsigned MEMWRITE_BIT = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b10
    } id_ex_state_e;

endpackage

// File: rtl/id_ex_entry.sv
// One ID/EX payload slot: PC, operands, immediate, register indices and
// control bundle, with synchronous clear taking priority over load.
module id_ex_entry #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 6,
    parameter int unsigned CTRL_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_W-1:0]  rs_o,
    output logic [REG_W-1:0]  rt_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic [DATA_W-1:0] pc_q, rs_data_q, rt_data_q, imm_q;
    logic [REG_W-1:0]  rs_q, rt_q, rd_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clr_i) begin
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
        end else if (load_i) begin
            pc_q      <= pc_i;
            rs_data_q <= rs_data_i;
            rt_data_q <= rt_data_i;
            imm_q     <= imm_i;
            rs_q      <= rs_i;
            rt_q      <= rt_i;
            rd_q      <= rd_i;
            ctrl_q    <= ctrl_i;
        end
    end

    assign pc_o      = pc_q;
    assign rs_data_o = rs_data_q;
    assign rt_data_o = rt_data_q;
    assign imm_o     = imm_q;
    assign rs_o      = rs_q;
    assign rt_o      = rt_q;
    assign rd_o      = rd_q;
    assign ctrl_o    = ctrl_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid/ready handshake, synchronous flush and an
// optional skid slot that lets in_ready be decoded purely from state.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 6,
    parameter int unsigned CTRL_W = id_ex_pkg::CTRL_W,
    parameter bit          SKID   = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);
    import id_ex_pkg::*;

    id_ex_state_e state_q, state_d;

    logic in_ready_w, out_valid_w, accept, consume;
    logic main_load, main_from_skid, skid_load;

    logic [DATA_W-1:0] main_pc, main_rs_data, main_rt_data, main_imm;
    logic [REG_W-1:0]  main_rs, main_rt, main_rd;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_pc, skid_rs_data, skid_rt_data, skid_imm;
    logic [REG_W-1:0]  skid_rs, skid_rt, skid_rd;
    logic [CTRL_W-1:0] skid_ctrl;

    assign out_valid_w = (state_q != EMPTY);
    assign accept      = in_valid & in_ready_w & ~flush;
    assign consume     = out_valid_w & out_ready;

    // Without a skid slot, HALF can only accept when main drains this cycle,
    // so the accept-without-consume path to FULL never fires for SKID=0.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d   = HALF;
                    main_load = 1'b1;
                end
                HALF: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (consume) begin
                    state_d        = HALF;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    id_ex_entry #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) u_main (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .clr_i     (flush),
        .load_i    (main_load),
        .pc_i      (main_from_skid ? skid_pc      : in_pc),
        .rs_data_i (main_from_skid ? skid_rs_data : in_rs_data),
        .rt_data_i (main_from_skid ? skid_rt_data : in_rt_data),
        .imm_i     (main_from_skid ? skid_imm     : in_imm),
        .rs_i      (main_from_skid ? skid_rs      : in_rs),
        .rt_i      (main_from_skid ? skid_rt      : in_rt),
        .rd_i      (main_from_skid ? skid_rd      : in_rd),
        .ctrl_i    (main_from_skid ? skid_ctrl    : in_ctrl),
        .pc_o      (main_pc),
        .rs_data_o (main_rs_data),
        .rt_data_o (main_rt_data),
        .imm_o     (main_imm),
        .rs_o      (main_rs),
        .rt_o      (main_rt),
        .rd_o      (main_rd),
        .ctrl_o    (main_ctrl)
    );

    if (SKID) begin : g_skid
        id_ex_entry #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) u_skid (
            .clk_i     (CLK),
            .rst_i     (RESET),
            .clr_i     (flush),
            .load_i    (skid_load),
            .pc_i      (in_pc),
            .rs_data_i (in_rs_data),
            .rt_data_i (in_rt_data),
            .imm_i     (in_imm),
            .rs_i      (in_rs),
            .rt_i      (in_rt),
            .rd_i      (in_rd),
            .ctrl_i    (in_ctrl),
            .pc_o      (skid_pc),
            .rs_data_o (skid_rs_data),
            .rt_data_o (skid_rt_data),
            .imm_o     (skid_imm),
            .rs_o      (skid_rs),
            .rt_o      (skid_rt),
            .rd_o      (skid_rd),
            .ctrl_o    (skid_ctrl)
        );
        assign in_ready_w = (state_q != FULL);
    end else begin : g_noskid
        assign skid_pc      = '0;
        assign skid_rs_data = '0;
        assign skid_rt_data = '0;
        assign skid_imm     = '0;
        assign skid_rs      = '0;
        assign skid_rt      = '0;
        assign skid_rd      = '0;
        assign skid_ctrl    = '0;
        assign in_ready_w   = ~out_valid_w | out_ready;
    end

    // Main keeps stale data after draining to EMPTY, so outputs are gated.
    assign in_ready    = in_ready_w;
    assign out_valid   = out_valid_w;
    assign out_pc      = out_valid_w ? main_pc      : '0;
    assign out_rs_data = out_valid_w ? main_rs_data : '0;
    assign out_rt_data = out_valid_w ? main_rt_data : '0;
    assign out_imm     = out_valid_w ? main_imm     : '0;
    assign out_rs      = out_valid_w ? main_rs      : '0;
    assign out_rt      = out_valid_w ? main_rt      : '0;
    assign out_rd      = out_valid_w ? main_rd      : '0;
    assign out_ctrl    = out_valid_w ? main_ctrl    : '0;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: SKID=1 and SKID=0 instances share stimulus; a
// negedge scoreboard tracks each one's expected contents.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [5:0]  rd;
        logic [12:0] ctrl;
    } pay_t;

    logic        CLK = 1'b0;
    logic        RESET, in_valid, flush, out_ready;
    logic [31:0] in_pc, in_rs_data, in_rt_data, in_imm;
    logic [5:0]  in_rs, in_rt, in_rd;
    logic [12:0] in_ctrl;

    logic        in_rdy  [2];
    logic        o_valid [2];
    logic [31:0] o_pc [2], o_rsd [2], o_rtd [2], o_imm [2];
    logic [5:0]  o_rs [2], o_rt [2], o_rd [2];
    logic [12:0] o_ctrl [2];

    pay_t exp_q [2][$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   seen28  = 1'b0;

    always #5 CLK = ~CLK;

    id_ex_stage_reg #(.DATA_W(32), .REG_W(6), .CTRL_W(13), .SKID(1'b1)) dut_skid (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_rdy[0]), .flush(flush),
        .in_pc(in_pc), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_pc(o_pc[0]), .out_rs_data(o_rsd[0]), .out_rt_data(o_rtd[0]), .out_imm(o_imm[0]),
        .out_rs(o_rs[0]), .out_rt(o_rt[0]), .out_rd(o_rd[0]), .out_ctrl(o_ctrl[0])
    );

    id_ex_stage_reg #(.DATA_W(32), .REG_W(6), .CTRL_W(13), .SKID(1'b0)) dut_noskid (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_rdy[1]), .flush(flush),
        .in_pc(in_pc), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_pc(o_pc[1]), .out_rs_data(o_rsd[1]), .out_rt_data(o_rtd[1]), .out_imm(o_imm[1]),
        .out_rs(o_rs[1]), .out_rt(o_rt[1]), .out_rd(o_rd[1]), .out_ctrl(o_ctrl[1])
    );

    // Scoreboard: compare against the queue head, then apply this edge's events.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            pay_t obs;
            pay_t cur;
            logic exp_ir;
            obs = {o_pc[k], o_rsd[k], o_rtd[k], o_imm[k], o_rs[k], o_rt[k], o_rd[k], o_ctrl[k]};
            cur = {in_pc, in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_rd, in_ctrl};
            if (RESET) exp_q[k].delete();
            exp_ir = (k == 0) ? (exp_q[k].size() < 2) : (exp_q[k].size() == 0 || out_ready);
            n_tests++;
            if (in_rdy[k] !== exp_ir) begin
                n_fail++;
                $display("FAIL sb_in_ready dut%0d t=%0t got=%b exp=%b", k, $time, in_rdy[k], exp_ir);
            end
            n_tests++;
            if (o_valid[k] !== (exp_q[k].size() != 0)) begin
                n_fail++;
                $display("FAIL sb_out_valid dut%0d t=%0t got=%b exp=%b", k, $time, o_valid[k], exp_q[k].size() != 0);
            end
            n_tests++;
            if (exp_q[k].size() == 0) begin
                if (obs !== '0) begin
                    n_fail++;
                    $display("FAIL sb_bubble dut%0d t=%0t got=%h exp=0", k, $time, obs);
                end
            end else if (obs !== exp_q[k][0]) begin
                n_fail++;
                $display("FAIL sb_payload dut%0d t=%0t got=%h exp=%h", k, $time, obs, exp_q[k][0]);
            end
            if (o_valid[k] === 1'b1 && o_pc[k] === 32'h28) seen28 = 1'b1;
            if (!RESET) begin
                if (flush) begin
                    exp_q[k].delete();
                end else begin
                    if (exp_q[k].size() != 0 && out_ready) void'(exp_q[k].pop_front());
                    if (in_valid && exp_ir) exp_q[k].push_back(cur);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [12:0] ctrl);
        in_valid   = v;
        in_pc      = pc;
        in_rs_data = pc ^ 32'h1111_0000;
        in_rt_data = pc + 32'h100;
        in_imm     = ~pc;
        in_rs      = pc[7:2];
        in_rt      = pc[7:2] + 6'd1;
        in_rd      = pc[7:2] ^ 6'h3F;
        in_ctrl    = ctrl;
    endtask

    task automatic test_reset();
        RESET = 1'b1; flush = 1'b0; out_ready = 1'b1;
        set_in(1'b1, 32'h40, 13'h1A5A);
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0 || o_pc[k] !== 32'h0 || o_ctrl[k] !== 13'h0 || in_rdy[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_state dut%0d got v=%b pc=%h ctrl=%h rdy=%b exp v=0 pc=0 ctrl=0 rdy=1",
                         k, o_valid[k], o_pc[k], o_ctrl[k], in_rdy[k]);
            end
        end
        RESET = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b1 || o_pc[k] !== 32'h40) begin
                n_fail++;
                $display("FAIL reset_first_accept dut%0d got v=%b pc=%h exp v=1 pc=00000040", k, o_valid[k], o_pc[k]);
            end
        end
        set_in(1'b1, 32'h44, 13'h0008);
        out_ready = 1'b0;
        tick();
        RESET = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0 || o_pc[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_async dut%0d got v=%b pc=%h exp v=0 pc=0", k, o_valid[k], o_pc[k]);
            end
        end
        tick();
        RESET = 1'b0; out_ready = 1'b1;
        set_in(1'b0, 32'h0, 13'h0);
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] pcs [4];
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
        out_ready = 1'b1;
        foreach (pcs[i]) begin
            set_in(1'b1, pcs[i], 13'h0100 + 13'(i));
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (o_valid[k] !== 1'b1 || o_pc[k] !== pcs[i]) begin
                    n_fail++;
                    $display("FAIL stream dut%0d got v=%b pc=%h exp v=1 pc=%h", k, o_valid[k], o_pc[k], pcs[i]);
                end
            end
        end
        set_in(1'b0, 32'h0, 13'h0);
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        set_in(1'b1, 32'h10, 13'h0808);
        tick();
        set_in(1'b1, 32'h14, 13'h0809);
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (in_rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ready_late got=%b exp=1", in_rdy[0]);
        end
        tick();
        set_in(1'b0, 32'h0, 13'h0);
        n_tests++;
        if (in_rdy[0] !== 1'b0 || o_pc[0] !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_full got rdy=%b pc=%h exp rdy=0 pc=00000010", in_rdy[0], o_pc[0]);
        end
        tick();
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (o_valid[0] !== 1'b1 || o_pc[0] !== 32'h14) begin
            n_fail++;
            $display("FAIL stall_release got v=%b pc=%h exp v=1 pc=00000014", o_valid[0], o_pc[0]);
        end
        tick();
        n_tests++;
        if (o_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drained got v=%b exp v=0", o_valid[0]);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 32'h20, 13'h1FFF);
        tick();
        set_in(1'b1, 32'h24, 13'h1FFF);
        tick();
        flush = 1'b1;
        set_in(1'b1, 32'h28, 13'h1FFF);
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 13'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0 || o_ctrl[k] !== 13'h0 || o_pc[k] !== 32'h0 || in_rdy[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_empty dut%0d got v=%b ctrl=%h pc=%h rdy=%b exp v=0 ctrl=0 pc=0 rdy=1",
                         k, o_valid[k], o_ctrl[k], o_pc[k], in_rdy[k]);
            end
        end
        tick(); tick();
        n_tests++;
        if (seen28 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_discard got seen28=%b exp=0", seen28);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        set_in(1'b1, 32'h30, 13'h1FFF);
        tick();
        set_in(1'b0, 32'h0, 13'h1FFF);
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (o_valid[k] !== 1'b0 || o_ctrl[k] !== 13'h0) begin
                    n_fail++;
                    $display("FAIL bubble dut%0d cyc=%0d got v=%b ctrl=%h exp v=0 ctrl=0", k, c, o_valid[k], o_ctrl[k]);
                end
            end
        end
        set_in(1'b1, 32'h34, 13'h1FFF);
        tick();
        n_tests++;
        if (o_pc[0] !== 32'h34 || o_ctrl[0] !== 13'h1FFF) begin
            n_fail++;
            $display("FAIL bubble_resume got pc=%h ctrl=%h exp pc=00000034 ctrl=1fff", o_pc[0], o_ctrl[0]);
        end
        set_in(1'b0, 32'h0, 13'h0);
        tick();
    endtask

    task automatic test_noskid();
        out_ready = 1'b1;
        set_in(1'b1, 32'h50, 13'h0011);
        tick();
        set_in(1'b0, 32'h0, 13'h0);
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (in_rdy[1] !== 1'b0 || in_rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_comb_ready got rdy1=%b rdy0=%b exp rdy1=0 rdy0=1", in_rdy[1], in_rdy[0]);
        end
        out_ready = 1'b1;
        set_in(1'b1, 32'h54, 13'h0012);
        #1;
        n_tests++;
        if (in_rdy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_ready_pass got=%b exp=1", in_rdy[1]);
        end
        tick();
        n_tests++;
        if (o_pc[1] !== 32'h54) begin
            n_fail++;
            $display("FAIL noskid_replace got pc=%h exp pc=00000054", o_pc[1]);
        end
        set_in(1'b1, 32'h58, 13'h0013);
        tick();
        n_tests++;
        if (o_pc[1] !== 32'h58 || o_valid[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_throughput got v=%b pc=%h exp v=1 pc=00000058", o_valid[1], o_pc[1]);
        end
        set_in(1'b0, 32'h0, 13'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        pc = 32'h1000;
        for (int c = 0; c < 300; c++) begin
            set_in(1'($urandom_range(0, 1)), pc, 13'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            pc = pc + 32'h4;
            tick();
        end
        flush = 1'b0;
        set_in(1'b0, 32'h0, 13'h0);
        out_ready = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (exp_q[k].size() != 0 || o_valid[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL drain dut%0d got left=%0d v=%b exp left=0 v=0", k, exp_q[k].size(), o_valid[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_noskid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
